// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - state encoding and width helpers for reset_sequencer
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        S_HOLD,
        S_GAP,
        S_WAIT_RDY,
        S_DONE
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int stage_w(input int n_ch);
        return $clog2(n_ch) + 1;
    endfunction

    function automatic int cnt_w(input int debounce_w, input int step_cycles, input int timeout_cycles);
        return max3(debounce_w, $clog2(step_cycles), $clog2(timeout_cycles));
    endfunction

endpackage

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered per-channel reset release with debounce, gaps and ready timeout
// Optional lock monitoring enabled by defining RESET_SEQUENCER_LOCK_MON_EN.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int DEBOUNCE_W     = 20,
    parameter int STEP_CYCLES    = 128,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       trigger_reset,
    input  logic                       pll_locked,
    input  logic [N_CH-1:0]            ch_ready,
    output logic [N_CH-1:0]            rst_out,
    output logic                       done,
    output logic [stage_w(N_CH)-1:0]   stage,
    output logic                       timeout_err,
    output logic [stage_w(N_CH)-1:0]   err_ch
);

    localparam int SW = stage_w(N_CH);
    localparam int CW = cnt_w(DEBOUNCE_W, STEP_CYCLES, TIMEOUT_CYCLES);

    localparam logic [CW-1:0] HOLD_LOAD  = CW'(2**DEBOUNCE_W - 1);
    localparam logic [CW-1:0] STEP_LOAD  = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] TO_LOAD    = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(N_CH - 1);

    seq_state_t      state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [N_CH-1:0] rst_out_nxt;
    logic [SW-1:0]   stage_nxt;
    logic            timeout_err_nxt;
    logic [SW-1:0]   err_ch_nxt;

    logic [N_CH-1:0] sel;
    logic            ready_cur;
    logic            lock_lost;
    logic            lock_hold;

    // One-hot mask of the channel currently being sequenced.
    assign sel       = N_CH'(1) << stage;
    assign ready_cur = |(ch_ready & sel);
    assign done      = (state == S_DONE);

`ifdef RESET_SEQUENCER_LOCK_MON_EN
    assign lock_lost = !pll_locked && (state != S_HOLD);
    assign lock_hold = !pll_locked;
`else
    logic unused_lock;
    assign unused_lock = pll_locked;
    assign lock_lost   = 1'b0;
    assign lock_hold   = 1'b0;
`endif

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        rst_out_nxt     = rst_out;
        stage_nxt       = stage;
        timeout_err_nxt = timeout_err;
        err_ch_nxt      = err_ch;

        if (trigger_reset || lock_lost) begin
            // Restart keeps the error record so software can still see it.
            state_nxt   = S_HOLD;
            cnt_nxt     = HOLD_LOAD;
            rst_out_nxt = '1;
            stage_nxt   = '0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (lock_hold) begin
                        cnt_nxt = HOLD_LOAD;
                    end else if (cnt == '0) begin
                        state_nxt = S_GAP;
                        cnt_nxt   = STEP_LOAD;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        rst_out_nxt = rst_out & ~sel;
                        state_nxt   = S_WAIT_RDY;
                        cnt_nxt     = TO_LOAD;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
                S_WAIT_RDY: begin
                    if (ready_cur || (cnt == '0)) begin
                        if (!ready_cur) begin
                            timeout_err_nxt = 1'b1;
                            err_ch_nxt      = stage;
                        end
                        if (stage == LAST_STAGE) begin
                            state_nxt = S_DONE;
                        end else begin
                            stage_nxt = stage + SW'(1);
                            state_nxt = S_GAP;
                            cnt_nxt   = STEP_LOAD;
                        end
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    rst_out_nxt = '0;
                end
                default: begin
                    state_nxt = S_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= S_HOLD;
            cnt         <= HOLD_LOAD;
            rst_out     <= '1;
            stage       <= '0;
            timeout_err <= 1'b0;
            err_ch      <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rst_out     <= rst_out_nxt;
            stage       <= stage_nxt;
            timeout_err <= timeout_err_nxt;
            err_ch      <= err_ch_nxt;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer (N_CH=3, DEBOUNCE_W=4, STEP=3, TIMEOUT=8)
module tb_reset_sequencer;

`ifdef RESET_SEQUENCER_LOCK_MON_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    localparam int SEL_RST   = 0;
    localparam int SEL_DONE  = 1;
    localparam int SEL_TERR  = 2;
    localparam int SEL_ERRCH = 3;
    localparam int SEL_STAGE = 4;

    logic       clk = 1'b0;
    logic       sys_rst;
    logic       trigger_reset;
    logic       pll_locked;
    logic [2:0] ch_ready;
    logic [2:0] rst_out;
    logic       done;
    logic [2:0] stage;
    logic       timeout_err;
    logic [2:0] err_ch;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        string tag;
        int    cyc;
        int    sel;
        int    val;
    } exp_t;

    exp_t sb[$];

    reset_sequencer #(
        .N_CH(3),
        .DEBOUNCE_W(4),
        .STEP_CYCLES(3),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .sys_clk(clk),
        .sys_rst(sys_rst),
        .trigger_reset(trigger_reset),
        .pll_locked(pll_locked),
        .ch_ready(ch_ready),
        .rst_out(rst_out),
        .done(done),
        .stage(stage),
        .timeout_err(timeout_err),
        .err_ch(err_ch)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (edge %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int obs(input int sel);
        case (sel)
            SEL_RST:   return int'(rst_out);
            SEL_DONE:  return int'(done);
            SEL_TERR:  return int'(timeout_err);
            SEL_ERRCH: return int'(err_ch);
            default:   return int'(stage);
        endcase
    endfunction

    task automatic expect_at(input string tag, input int c, input int sel, input int val);
        exp_t e;
        int   i;
        e.tag = tag;
        e.cyc = c;
        e.sel = sel;
        e.val = val;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endtask

    // Uninterrupted release with every channel ready, counted from restart edge l.
    task automatic expect_seq(input string pfx, input int l);
        expect_at({pfx, "_rst0_held"}, l + 18, SEL_RST, 7);
        expect_at({pfx, "_rst0_fall"}, l + 19, SEL_RST, 6);
        expect_at({pfx, "_stage1"},    l + 20, SEL_STAGE, 1);
        expect_at({pfx, "_rst1_held"}, l + 22, SEL_RST, 6);
        expect_at({pfx, "_rst1_fall"}, l + 23, SEL_RST, 4);
        expect_at({pfx, "_stage2"},    l + 24, SEL_STAGE, 2);
        expect_at({pfx, "_rst2_held"}, l + 26, SEL_RST, 4);
        expect_at({pfx, "_rst2_fall"}, l + 27, SEL_RST, 0);
        expect_at({pfx, "_done_low"},  l + 27, SEL_DONE, 0);
        expect_at({pfx, "_done_high"}, l + 28, SEL_DONE, 1);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc == cyc) check_eq(e.tag, obs(e.sel), e.val);
            else check_eq({e.tag, "_late"}, cyc, e.cyc);
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            check_eq("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic pulse_trigger(output int t);
        trigger_reset = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        trigger_reset = 1'b0;
    endtask

    initial begin
        int r, t1, t2, t3, t4, d;
        sys_rst       = 1'b1;
        trigger_reset = 1'b0;
        pll_locked    = 1'b1;
        ch_ready      = 3'b000;

        // Release order after sys_rst
        @(negedge clk);
        ch_ready = 3'b111;
        r = cyc + 1;
        expect_at("rst_vec",   r, SEL_RST, 7);
        expect_at("rst_stage", r, SEL_STAGE, 0);
        expect_at("rst_done",  r, SEL_DONE, 0);
        expect_at("rst_terr",  r, SEL_TERR, 0);
        expect_at("rst_errch", r, SEL_ERRCH, 0);
        expect_seq("order", r);
        expect_at("order_terr", r + 28, SEL_TERR, 0);
        @(negedge clk);
        sys_rst = 1'b0;
        drain();

        // Ready timeout on channel 1
        ch_ready = 3'b101;
        pulse_trigger(r);
        expect_at("to_rst0_fall", r + 19, SEL_RST, 6);
        expect_at("to_rst1_fall", r + 23, SEL_RST, 4);
        expect_at("to_terr_pre",  r + 30, SEL_TERR, 0);
        expect_at("to_terr_set",  r + 31, SEL_TERR, 1);
        expect_at("to_errch",     r + 31, SEL_ERRCH, 1);
        expect_at("to_stage2",    r + 31, SEL_STAGE, 2);
        expect_at("to_rst2_held", r + 33, SEL_RST, 4);
        expect_at("to_rst2_fall", r + 34, SEL_RST, 0);
        expect_at("to_done",      r + 35, SEL_DONE, 1);
        drain();

        // Restart while stage 1 is in its gap
        ch_ready = 3'b111;
        pulse_trigger(t1);
        expect_at("mid_rst0_fall", t1 + 19, SEL_RST, 6);
        expect_at("mid_stage1",    t1 + 20, SEL_STAGE, 1);
        wait_until(t1 + 20);
        pulse_trigger(t2);
        expect_at("mid_vec",   t2, SEL_RST, 7);
        expect_at("mid_stage", t2, SEL_STAGE, 0);
        expect_at("mid_done",  t2, SEL_DONE, 0);
        expect_at("mid_terr",  t2, SEL_TERR, 1);
        expect_at("mid_errch", t2, SEL_ERRCH, 1);
        expect_seq("mid", t2);
        expect_at("mid_terr_end", t2 + 28, SEL_TERR, 1);
        drain();

        // Restart and ready on the same edge
        ch_ready = 3'b000;
        pulse_trigger(t3);
        expect_at("sim_rst0_fall", t3 + 19, SEL_RST, 6);
        wait_until(t3 + 21);
        trigger_reset = 1'b1;
        ch_ready      = 3'b111;
        t4 = cyc + 1;
        @(negedge clk);
        trigger_reset = 1'b0;
        expect_at("sim_stage", t4, SEL_STAGE, 0);
        expect_at("sim_vec",   t4, SEL_RST, 7);
        expect_seq("sim", t4);
        drain();

        // Lock loss in DONE, then held low in HOLD
        pll_locked = 1'b0;
        d = cyc;
        expect_at("lock_vec",      d + 1,  SEL_RST, LOCK_EN ? 7 : 0);
        expect_at("lock_done",     d + 1,  SEL_DONE, LOCK_EN ? 0 : 1);
        expect_at("lock_hold_vec", d + 30, SEL_RST, LOCK_EN ? 7 : 0);
        expect_at("lock_rst0_pre", d + 68, SEL_RST, LOCK_EN ? 7 : 0);
        expect_at("lock_rst0",     d + 69, SEL_RST, LOCK_EN ? 6 : 0);
        wait_until(d + 50);
        pll_locked = 1'b1;
        drain();

        // sys_rst wins over trigger_reset and clears the error record
        sys_rst       = 1'b1;
        trigger_reset = 1'b1;
        r = cyc + 1;
        expect_at("prio_terr",  r, SEL_TERR, 0);
        expect_at("prio_errch", r, SEL_ERRCH, 0);
        expect_at("prio_vec",   r, SEL_RST, 7);
        expect_at("prio_stage", r, SEL_STAGE, 0);
        @(negedge clk);
        sys_rst       = 1'b0;
        trigger_reset = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of sequenced reset channels, range 1..16.
REQ-002 SHALL have parameter DEBOUNCE_W, default 20: width of the debounce counter; hold time is 2^DEBOUNCE_W-1 cycles.
REQ-003 SHALL have parameter STEP_CYCLES, default 128: gap in cycles before each channel release; must be >= 1.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum wait for a channel ready; must be >= 1.
REQ-005 SHALL have port sys_clk, input, 1: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port sys_rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port trigger_reset, input, 1: restart request, synchronous.
REQ-008 SHALL have port pll_locked, input, 1: PLL lock status; used only under REQ-025.
REQ-009 SHALL have port ch_ready, input, N_CH: per-channel "out of reset" acknowledge.
REQ-010 SHALL have port rst_out, output, N_CH: per-channel reset, active-high, registered.
REQ-011 SHALL have port done, output, 1: all channels released.
REQ-012 SHALL have port stage, output, $clog2(N_CH)+1: index of the channel being sequenced.
REQ-013 SHALL have port timeout_err, output, 1: sticky flag, set when a ready timeout occurs.
REQ-014 SHALL have port err_ch, output, $clog2(N_CH)+1: index of the last channel that timed out.

Function
REQ-015 SHALL implement the FSM states HOLD, GAP, WAIT_RDY and DONE, with one shared down-counter cnt.
REQ-016 A restart condition (trigger_reset high, or lock loss per REQ-025) sampled in any state SHALL take effect on the next edge:
- state <= HOLD;
- cnt <= 2^DEBOUNCE_W-1;
- rst_out <= all ones;
- stage <= 0;
- done <= 0;
- timeout_err and err_ch are kept.
REQ-017 In HOLD, cnt SHALL decrement each cycle; when cnt==0, the FSM SHALL move to GAP with cnt <= STEP_CYCLES-1.
REQ-018 In GAP, cnt SHALL decrement each cycle; when cnt==0, the FSM SHALL apply the following on that edge:
- rst_out[stage] <= 0;
- state <= WAIT_RDY;
- cnt <= TIMEOUT_CYCLES-1.
REQ-019 In WAIT_RDY, when ch_ready[stage] is high the FSM SHALL advance:
- if stage==N_CH-1, go to DONE;
- otherwise stage <= stage+1 and go to GAP with cnt <= STEP_CYCLES-1.
REQ-020 In WAIT_RDY, when ch_ready[stage] is low and cnt==0, the FSM SHALL record the error and advance:
- timeout_err <= 1;
- err_ch <= stage;
- advance exactly as in REQ-019.
- Otherwise cnt SHALL decrement.
REQ-021 In DONE, the outputs SHALL be done=1 and rst_out=0; the FSM SHALL stay in DONE until a restart condition.
REQ-022 A released channel SHALL stay released until a restart condition. ch_ready SHALL be sampled only for the current stage, only in WAIT_RDY, and channels SHALL be released strictly in index order 0..N_CH-1.
REQ-023 Timing with no restart: rst_out[0] SHALL fall at edge L + 2^DEBOUNCE_W + STEP_CYCLES, where L is the last edge that samples a restart condition. Each later rst_out[k] SHALL fall STEP_CYCLES edges after the edge that samples ch_ready[k-1] high (or the timeout edge).

Reset
REQ-024 On sys_rst, all of the following SHALL take their reset values in one cycle, and sys_rst SHALL take priority over trigger_reset:
- state = HOLD;
- cnt = 2^DEBOUNCE_W-1;
- rst_out = all ones;
- stage = 0;
- done = 0;
- timeout_err = 0;
- err_ch = 0.

Configuration
REQ-025 With RESET_SEQUENCER_LOCK_MON_EN defined:
- pll_locked==0 in GAP, WAIT_RDY or DONE SHALL be a restart condition;
- in HOLD, pll_locked==0 SHALL hold cnt at 2^DEBOUNCE_W-1.
REQ-026 Without RESET_SEQUENCER_LOCK_MON_EN, pll_locked SHALL be ignored; the port remains present.

Structure
REQ-027 The state enum and the width helpers SHALL live in reset_sequencer_pkg.
REQ-028 The block SHALL have no sub-module: one FSM and one counter of width max(DEBOUNCE_W, $clog2(STEP_CYCLES), $clog2(TIMEOUT_CYCLES)).

Verification
REQ-029 The bench SHALL cover the following directed scenarios, each with N_CH=3, DEBOUNCE_W=4, STEP_CYCLES=3, TIMEOUT_CYCLES=8:
- Release order: sys_rst for 1 cycle, then ch_ready tied to 3'b111 -> rst_out[0] falls 19 edges after the reset edge, rst_out[1] 4 edges later, rst_out[2] 4 edges after that, then done=1 and timeout_err=0.
- Timeout: ch_ready[1] held low -> timeout_err=1 and err_ch=1 exactly 8 edges after rst_out[1] falls; rst_out[2] still releases; done=1.
- Mid-sequence restart: trigger_reset pulsed while stage==1 -> rst_out=3'b111, stage=0, done=0 next edge; timeout_err retained; full sequence repeats per REQ-023.
- Simultaneous restart: trigger_reset and ch_ready[stage] high on the same edge -> restart wins and stage=0.
- Lock monitoring with RESET_SEQUENCER_LOCK_MON_EN: pll_locked low in DONE -> rst_out=3'b111 next edge; pll_locked held low 50 cycles in HOLD -> rst_out[0] falls 19 edges after pll_locked rises.
- Lock monitoring without RESET_SEQUENCER_LOCK_MON_EN: the same pll_locked stimulus -> no effect.
